// File: rtl/lzd_share_arbiter.sv
// lzd_share_arbiter: one registered leading-zero-count stage shared by NUM_REQ
// valid/ready requesters. Grants one word per cycle and returns
// {requester id, leading-zero count, all-zero flag} on a valid/ready
// response port with backpressure and full throughput.
//
// Build option LZD_SHARE_FIXED_PRIO_EN: when defined, the lowest valid index
// always wins and no round-robin pointer exists. When undefined (default),
// the search is round-robin starting at rr_ptr.
module lzd_share_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
  output logic [$clog2(DATA_WIDTH):0]       rsp_count,
  output logic                              rsp_zero
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  // Count of consecutive zeros from the MSB; an all-zero word yields DATA_WIDTH.
  function automatic logic [CW-1:0] lzc(input logic [DATA_WIDTH-1:0] w);
    logic [CW-1:0] n;
    logic          hit;
    n   = '0;
    hit = 1'b0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (w[i]) hit = 1'b1;
      else if (!hit) n = n + CW'(1);
    end
    return n;
  endfunction

  logic                  stage_free;
  logic                  found_p0;
  logic                  accept_p0;
  logic [IW-1:0]         gnt_p0;
  logic [DATA_WIDTH-1:0] word_p0;
  logic [CW-1:0]         cnt_p0;
  logic                  zero_p0;

  logic                  vld_p1;
  logic [IW-1:0]         id_p1;
  logic [CW-1:0]         cnt_p1;
  logic                  zero_p1;

`ifndef LZD_SHARE_FIXED_PRIO_EN
  logic [IW-1:0]         rr_ptr;
`endif

  // ---- stage p0: arbitration and combinational count of the granted word ----
  // Grant search; req_ready is built only from req_valid, rsp_ready, reset and
  // state. Gating with rst_n keeps req_ready low while reset is held.
  always_comb begin
    int idx;
    idx        = 0;
    stage_free = rst_n && (!vld_p1 || rsp_ready);
    found_p0   = 1'b0;
    gnt_p0     = '0;
    word_p0    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef LZD_SHARE_FIXED_PRIO_EN
      idx = k;
`else
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`endif
      if (!found_p0 && req_valid[idx]) begin
        found_p0 = 1'b1;
        gnt_p0   = IW'(idx);
        word_p0  = req_data[idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    accept_p0 = stage_free && found_p0;
    req_ready = '0;
    if (accept_p0) req_ready[gnt_p0] = 1'b1;
  end

  // Leading-zero count and all-zero flag of the granted word.
  always_comb begin
    cnt_p0  = lzc(word_p0);
    zero_p0 = ~|word_p0;
  end

  // ---- stage p1: result register ----
  // Load on accept (also when consuming the previous result); clear when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      id_p1   <= '0;
      cnt_p1  <= '0;
      zero_p1 <= 1'b0;
    end else if (accept_p0) begin
      vld_p1  <= 1'b1;
      id_p1   <= gnt_p0;
      cnt_p1  <= cnt_p0;
      zero_p1 <= zero_p0;
    end else if (rsp_ready) begin
      vld_p1  <= 1'b0;
    end
  end

`ifndef LZD_SHARE_FIXED_PRIO_EN
  // Round-robin pointer moves past the winner on accept; holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (accept_p0) begin
      rr_ptr <= (int'(gnt_p0) == NUM_REQ - 1) ? '0 : gnt_p0 + IW'(1);
    end
  end
`endif

  assign rsp_valid = vld_p1;
  assign rsp_id    = id_p1;
  assign rsp_count = cnt_p1;
  assign rsp_zero  = zero_p1;

endmodule
